// File: rtl/fp_mul_pkg.sv
// ----------------------------------------------------------------------------
// fp_mul_pkg
// Shared definitions for the fp_mul_sched block: operand/rounding widths,
// rounding-mode encodings and the result flag pair.
// No ports (package).
// ----------------------------------------------------------------------------
package fp_mul_pkg;

   localparam int unsigned FP_W = 32;
   localparam int unsigned RM_W = 3;

   // Codes 101..111 are reserved; the scheduler never interprets rmode, it
   // only forwards it to the multiplier.
   typedef enum logic [RM_W-1:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rmode_e;

   typedef struct packed {
      logic ovrf;
      logic udrf;
   } fp_flags_t;

endpackage

// File: rtl/fp_mul_rr_arb.sv
// ----------------------------------------------------------------------------
// fp_mul_rr_arb
// NREQ-wide round-robin arbiter with one-hot grant. The search starts at the
// pointer; after a grant the pointer moves to (winner+1) mod NREQ, otherwise
// it holds.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   i_req      : request vector (already qualified by the caller)
//   o_gnt      : one-hot grant, combinational
//   o_win      : index of the granted requester (valid when o_any)
//   o_any      : a grant is issued this cycle
// ----------------------------------------------------------------------------
module fp_mul_rr_arb #(
   parameter int unsigned NREQ = 4,
   localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_win,
   output logic            o_any
);

   logic [IW-1:0] r_ptr;

   // Two passes: first the requesters at or above the pointer, then wrap
   // around to the lowest requester overall.
   always_comb begin
      o_gnt = '0;
      o_win = '0;
      o_any = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!o_any && i_req[i] && (i >= 32'(r_ptr))) begin
            o_any    = 1'b1;
            o_win    = IW'(i);
            o_gnt[i] = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!o_any && i_req[i]) begin
            o_any    = 1'b1;
            o_win    = IW'(i);
            o_gnt[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (o_any) begin
         r_ptr <= (o_win == IW'(NREQ - 1)) ? '0 : o_win + IW'(1);
      end
   end

endmodule

// File: rtl/fp_mul_sched.sv
// ----------------------------------------------------------------------------
// fp_mul_sched
// Shares one combinational FP multiplier among NREQ requesters. A granted
// request is registered (ISSUE), the multiplier result is captured at the
// end of that cycle into the requester's result slot, and held until the
// requester takes it. One outstanding operation per requester.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : per-requester request handshake (ready = grant)
//   req_x, req_y, req_rmode: per-requester operands, NREQ x 32/32/3 packed
//   rsp_valid/rsp_ready    : per-requester result handshake
//   rsp_z, rsp_flags       : per-requester result and {ovrf,udrf}
//   mul_x, mul_y, mul_rmode: to shared multiplier (zero when idle)
//   mul_z, mul_ovrf/udrf   : from shared multiplier
//   busy                   : operation in flight or any result pending
// Optional (macro FP_MUL_SCHED_STATS_EN):
//   stat_ops, stat_ovrf, stat_udrf : saturating 16-bit capture counters
// ----------------------------------------------------------------------------
module fp_mul_sched
   import fp_mul_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_x,
   input  logic [NREQ*FP_W-1:0] req_y,
   input  logic [NREQ*RM_W-1:0] req_rmode,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [NREQ*FP_W-1:0] rsp_z,
   output logic [NREQ*2-1:0]    rsp_flags,
   output logic [FP_W-1:0]      mul_x,
   output logic [FP_W-1:0]      mul_y,
   output logic [RM_W-1:0]      mul_rmode,
   input  logic [FP_W-1:0]      mul_z,
   input  logic                 mul_ovrf,
   input  logic                 mul_udrf,
   output logic                 busy
`ifdef FP_MUL_SCHED_STATS_EN
   ,
   output logic [15:0]          stat_ops,
   output logic [15:0]          stat_ovrf,
   output logic [15:0]          stat_udrf
`endif
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]          r_state;
   logic [NREQ-1:0]     r_pending;
   logic [NREQ-1:0]     r_rsp_valid;
   logic [FP_W-1:0]     r_x;
   logic [FP_W-1:0]     r_y;
   logic [RM_W-1:0]     r_rm;
   logic [IW-1:0]       r_tag;
   logic [NREQ*FP_W-1:0] r_rsp_z;
   logic [NREQ*2-1:0]   r_rsp_flags;

   logic [NREQ-1:0]     w_elig;
   logic [NREQ-1:0]     w_gnt;
   logic [IW-1:0]       w_win;
   logic                w_any;
   logic                w_issue;
   logic [NREQ-1:0]     w_drain;
   logic [NREQ-1:0]     w_cap;
   logic [FP_W-1:0]     w_sel_x;
   logic [FP_W-1:0]     w_sel_y;
   logic [RM_W-1:0]     w_sel_rm;
   fp_flags_t           w_flags;

   // Eligibility uses the registered pending bit, so a drain and a new
   // request in the same cycle cost one bubble. Reset masks all grants.
   assign w_elig  = req_valid & ~r_pending & {NREQ{rst_n}};
   assign w_issue = (r_state == ST_ISSUE);
   assign w_drain = r_rsp_valid & rsp_ready;
   assign w_flags = '{ovrf: mul_ovrf, udrf: mul_udrf};

   fp_mul_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_elig),
      .o_gnt (w_gnt),
      .o_win (w_win),
      .o_any (w_any)
   );

   // One-hot mux of the winner's operands, plus capture decode of the tag.
   always_comb begin
      w_sel_x  = '0;
      w_sel_y  = '0;
      w_sel_rm = '0;
      w_cap    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_sel_x  = w_sel_x  | (req_x[i*FP_W +: FP_W]     & {FP_W{w_gnt[i]}});
         w_sel_y  = w_sel_y  | (req_y[i*FP_W +: FP_W]     & {FP_W{w_gnt[i]}});
         w_sel_rm = w_sel_rm | (req_rmode[i*RM_W +: RM_W] & {RM_W{w_gnt[i]}});
         w_cap[i] = w_issue && (r_tag == IW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pending   <= '0;
         r_rsp_valid <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_rm        <= '0;
         r_tag       <= '0;
         r_rsp_z     <= '0;
         r_rsp_flags <= '0;
      end else begin
         r_state <= w_any ? ST_ISSUE : ST_IDLE;
         if (w_any) begin
            r_x   <= w_sel_x;
            r_y   <= w_sel_y;
            r_rm  <= w_sel_rm;
            r_tag <= w_win;
         end
         // A slot being captured is never being drained: its result is not
         // valid yet while its operation is still in flight.
         r_pending   <= (r_pending & ~w_drain) | w_gnt;
         r_rsp_valid <= (r_rsp_valid & ~w_drain) | w_cap;
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_cap[i]) begin
               r_rsp_z[i*FP_W +: FP_W] <= mul_z;
               r_rsp_flags[i*2 +: 2]   <= w_flags;
            end
         end
      end
   end

`ifdef FP_MUL_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_ops  <= '0;
         stat_ovrf <= '0;
         stat_udrf <= '0;
      end else if (w_issue) begin
         if (stat_ops != 16'hFFFF)
            stat_ops <= stat_ops + 16'd1;
         if (mul_ovrf && (stat_ovrf != 16'hFFFF))
            stat_ovrf <= stat_ovrf + 16'd1;
         if (mul_udrf && (stat_udrf != 16'hFFFF))
            stat_udrf <= stat_udrf + 16'd1;
      end
   end
`endif

   assign req_ready = w_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_z     = r_rsp_z;
   assign rsp_flags = r_rsp_flags;
   assign mul_x     = w_issue ? r_x  : '0;
   assign mul_y     = w_issue ? r_y  : '0;
   assign mul_rmode = w_issue ? r_rm : '0;
   assign busy      = w_issue | (|r_pending);

endmodule

// File: tb/tb_fp_mul_sched.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_sched
// Directed bench for fp_mul_sched (NREQ=4) with a small stand-in multiplier:
//   z    = y                 when x == 1.0 (0x3F800000)
//        = x ^ y ^ rmode      otherwise
//   ovrf = (x == 0x7F000000), udrf = (x == 0x00800000)
// Optional stats ports are connected when FP_MUL_SCHED_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_fp_mul_sched;

   localparam int unsigned NREQ = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_x;
   logic [NREQ*32-1:0] req_y;
   logic [NREQ*3-1:0] req_rmode;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [NREQ*32-1:0] rsp_z;
   logic [NREQ*2-1:0] rsp_flags;
   logic [31:0]       mul_x;
   logic [31:0]       mul_y;
   logic [2:0]        mul_rmode;
   logic [31:0]       mul_z;
   logic              mul_ovrf;
   logic              mul_udrf;
   logic              busy;
`ifdef FP_MUL_SCHED_STATS_EN
   logic [15:0]       stat_ops;
   logic [15:0]       stat_ovrf;
   logic [15:0]       stat_udrf;
`endif

   int n_vec;
   int n_bad;

   logic [2:0] rm_tab  [4];
   logic [3:0] gnt_exp [3];

   fp_mul_sched #(
      .NREQ (NREQ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_rmode (req_rmode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .rsp_flags (rsp_flags),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_rmode (mul_rmode),
      .mul_z     (mul_z),
      .mul_ovrf  (mul_ovrf),
      .mul_udrf  (mul_udrf),
      .busy      (busy)
`ifdef FP_MUL_SCHED_STATS_EN
      ,
      .stat_ops  (stat_ops),
      .stat_ovrf (stat_ovrf),
      .stat_udrf (stat_udrf)
`endif
   );

   always_comb begin
      mul_z    = (mul_x == 32'h3F80_0000) ? mul_y : (mul_x ^ mul_y ^ {29'd0, mul_rmode});
      mul_ovrf = (mul_x == 32'h7F00_0000);
      mul_udrf = (mul_x == 32'h0080_0000);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm);
      req_x[i*32 +: 32]    = x;
      req_y[i*32 +: 32]    = y;
      req_rmode[i*3 +: 3]  = rm;
   endtask

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      rm_tab[0]  = 3'd0;
      rm_tab[1]  = 3'd5;
      rm_tab[2]  = 3'd7;
      rm_tab[3]  = 3'd4;
      gnt_exp[0] = 4'b0100;
      gnt_exp[1] = 4'b1000;
      gnt_exp[2] = 4'b0001;

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_x     = '0;
      req_y     = '0;
      req_rmode = '0;
      tick();
      tick();

      // Reset state; no grant while reset is asserted
      req_valid = 4'hF;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rspv",  32'(rsp_valid), 32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      chk("rst_mulx",  mul_x,          32'h0);
      chk("rst_rspz0", rsp_z[31:0],    32'h0);
      req_valid = '0;

      // 1.0 * 2.0 on requester 0, result held until taken
      rst_n = 1'b1;
      set_req(0, 32'h3F80_0000, 32'h4000_0000, 3'b000);
      req_valid = 4'b0001;
      #1;
      chk("t1_gnt", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("t1_mulx",    mul_x,           32'h3F80_0000);
      chk("t1_muly",    mul_y,           32'h4000_0000);
      chk("t1_rspv_e1", 32'(rsp_valid),  32'h0);
      chk("t1_busy",    32'(busy),       32'h1);
      tick();
      chk("t1_rspv_e2", 32'(rsp_valid),  32'h1);
      chk("t1_rspz",    rsp_z[31:0],     32'h4000_0000);
      chk("t1_flags",   32'(rsp_flags[1:0]), 32'h0);
      chk("t1_mulx_idle", mul_x,         32'h0);
      tick();
      chk("t1_hold_z",  rsp_z[31:0],     32'h4000_0000);
      chk("t1_hold_v",  32'(rsp_valid),  32'h1);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      chk("t1_drain_v", 32'(rsp_valid),  32'h0);
      chk("t1_idle_busy", 32'(busy),     32'h0);

      // All four requesting from reset: grants and responses in order 0..3
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         set_req(i, 32'h3F80_0000, 32'h4040_0000 + 32'(i), rm_tab[i]);
      req_valid = 4'hF;
      rsp_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_gnt", 32'(req_ready), 32'h1 << k);
         tick();
         req_valid[k] = 1'b0;
         chk("t2_rmode", 32'(mul_rmode), 32'(rm_tab[k]));
         chk("t2_muly",  mul_y,          32'h4040_0000 + 32'(k));
         chk("t2_rspv",  32'(rsp_valid), (k == 0) ? 32'h0 : (32'h1 << (k - 1)));
         if (k > 0)
            chk("t2_rspz", rsp_z[(k-1)*32 +: 32], 32'h4040_0000 + 32'(k - 1));
      end
      tick();
      chk("t2_rspv_last", 32'(rsp_valid), 32'h8);
      chk("t2_rspz_last", rsp_z[127:96],  32'h4040_0003);
      tick();
      chk("t2_rspv_end",  32'(rsp_valid), 32'h0);
      chk("t2_busy_end",  32'(busy),      32'h0);

      // Requester 1 blocked by its unconsumed result while 0,2,3 proceed
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      rsp_ready = 4'b1101;
      set_req(1, 32'h3F80_0000, 32'h4100_0000, 3'b000);
      req_valid = 4'b0010;
      #1;
      chk("t3_gnt1", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      chk("t3_rspv1", 32'(rsp_valid), 32'h2);
      set_req(0, 32'h3F80_0000, 32'h40A0_0000, 3'b000);
      set_req(2, 32'h3F80_0000, 32'h40C0_0000, 3'b000);
      set_req(3, 32'h3F80_0000, 32'h40E0_0000, 3'b000);
      set_req(1, 32'h7F00_0000, 32'h4000_0000, 3'b000);
      req_valid = 4'hF;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("t3_gnt",  32'(req_ready),    32'(gnt_exp[j]));
         chk("t3_blk1", 32'(req_ready[1]), 32'h0);
         tick();
         req_valid = req_valid & ~gnt_exp[j];
         chk("t3_hold", rsp_z[63:32], 32'h4100_0000);
      end
      tick();
      tick();
      chk("t3_busy_pend", 32'(busy),      32'h1);
      chk("t3_rspv_only1", 32'(rsp_valid), 32'h2);
`ifdef FP_MUL_SCHED_STATS_EN
      chk("t3_sops0",  32'(stat_ops),  32'd4);
      chk("t3_sovrf0", 32'(stat_ovrf), 32'd0);
`endif
      // Drain and re-request in the same cycle: one bubble, then grant
      rsp_ready = 4'hF;
      #1;
      chk("t3_bubble", 32'(req_ready), 32'h0);
      tick();
      rsp_ready = 4'b1101;
      chk("t3_regnt", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      chk("t3_ovf_v",     32'(rsp_valid),      32'h2);
      chk("t3_ovf_z",     rsp_z[63:32],        32'h3F00_0000);
      chk("t3_ovf_flags", 32'(rsp_flags[3:2]), 32'h2);
`ifdef FP_MUL_SCHED_STATS_EN
      chk("t3_sops1",  32'(stat_ops),  32'd5);
      chk("t3_sovrf1", 32'(stat_ovrf), 32'd1);
`endif
      rsp_ready = 4'hF;
      tick();
      chk("t3_busy_end", 32'(busy), 32'h0);

      // Reset the cycle after a grant: operation discarded, pointer back to 0
      rsp_ready = '0;
      set_req(2, 32'h3F80_0000, 32'h1234_5678, 3'b000);
      req_valid = 4'b0100;
      #1;
      chk("t4_gnt", 32'(req_ready), 32'h4);
      tick();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("t4_rst_ready", 32'(req_ready), 32'h0);
      tick();
      rst_n     = 1'b1;
      req_valid = '0;
      tick();
      chk("t4_rspv", 32'(rsp_valid), 32'h0);
      chk("t4_busy", 32'(busy),      32'h0);
      chk("t4_mulx", mul_x,          32'h0);
      set_req(1, 32'h0080_0000, 32'h0000_0003, 3'b110);
      req_valid = 4'b1010;
      #1;
      chk("t4_ptr0", 32'(req_ready), 32'h2);

      // Underflow flag and reserved rounding mode on requester 1
      tick();
      req_valid = '0;
      chk("t5_rmode", 32'(mul_rmode), 32'h6);
      tick();
      chk("t5_rspv",  32'(rsp_valid),      32'h2);
      chk("t5_rspz",  rsp_z[63:32],        32'h0080_0005);
      chk("t5_flags", 32'(rsp_flags[3:2]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
